// File: rtl/money_accumulator_if.sv
// ----------------------------------------------------------------------------
// money_accumulator_if
// Purpose : bundles the request/response signals of the money accumulator so
//           the block and its driver connect through one port.
// Signals : pulse  [NCH]       per-channel denomination pulse level
//           target [VALW]      required amount, sampled on start
//           start              one-cycle transaction request
//           ack                releases the DONE state
//           out                high while DONE
//           busy               high while ACCUM
//           counts [NCH*CNTW]  per-channel accepted pulse counts
//           total  [VALW]      accumulated amount of current transaction
//           change [VALW]      total minus latched target while out, else 0
//           ovf                sticky saturation flag
// Modports: master drives requests (testbench/host), slave is the accumulator.
// ----------------------------------------------------------------------------
interface money_accumulator_if #(
    parameter int NCH  = 3,
    parameter int VALW = 19,
    parameter int CNTW = 9
);
    logic [NCH-1:0]      pulse;
    logic [VALW-1:0]     target;
    logic                start;
    logic                ack;
    logic                out;
    logic                busy;
    logic [NCH*CNTW-1:0] counts;
    logic [VALW-1:0]     total;
    logic [VALW-1:0]     change;
    logic                ovf;

    modport master (
        output pulse, target, start, ack,
        input  out, busy, counts, total, change, ovf
    );

    modport slave (
        input  pulse, target, start, ack,
        output out, busy, counts, total, change, ovf
    );
endinterface

// File: rtl/money_accumulator.sv
// ----------------------------------------------------------------------------
// money_accumulator
// Purpose : counts rising edges on NCH denomination pulse channels, adds the
//           matching denomination values into a running total, and reports
//           completion once the total reaches a target latched at start.
//           Sums and counts saturate at all-ones and set a sticky ovf flag.
// Ports   : clk  - sole clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - money_accumulator_if.slave (see interface for signal list)
// ----------------------------------------------------------------------------
module money_accumulator #(
    parameter int                  NCH   = 3,
    parameter int                  VALW  = 19,
    parameter int                  CNTW  = 9,
    parameter logic [NCH*VALW-1:0] DENOM = {19'd5000, 19'd2000, 19'd1000}
) (
    input logic               clk,
    input logic               rst,
    money_accumulator_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Four guard bits hold the sum of the total plus up to eight channel
    // values without wrapping, so saturation can be detected exactly.
    localparam int              SUMW    = VALW + 4;
    localparam logic [SUMW-1:0] VAL_MAX = {4'b0000, {VALW{1'b1}}};

    logic [1:0]          state;
    logic [NCH-1:0]      pulse_prev;
    logic [NCH-1:0]      events;
    logic [VALW-1:0]     target_q;
    logic [VALW-1:0]     total_q;
    logic [NCH*CNTW-1:0] counts_q;
    logic                ovf_q;

    logic [SUMW-1:0]     sum_raw;
    logic                sum_ovf;
    logic [VALW-1:0]     total_next;
    logic [NCH*CNTW-1:0] counts_next;
    logic                cnt_ovf;

    // pulse_prev tracks the input in every state, so a level that is already
    // high when ACCUM is entered never looks like a fresh edge.
    assign events = bus.pulse & ~pulse_prev;

    // NOTE: every variable in an always_comb gets a default before any
    // conditional update; otherwise synthesis infers a latch.
    always_comb begin
        sum_raw = {4'b0000, total_q};
        for (int i = 0; i < NCH; i++) begin
            if (events[i]) begin
                sum_raw = sum_raw + SUMW'(DENOM[i*VALW +: VALW]);
            end
        end
        sum_ovf    = (sum_raw > VAL_MAX);
        total_next = sum_ovf ? {VALW{1'b1}} : sum_raw[VALW-1:0];
    end

    always_comb begin
        counts_next = counts_q;
        cnt_ovf     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (events[i]) begin
                if (&counts_q[i*CNTW +: CNTW]) begin
                    cnt_ovf = 1'b1;
                end else begin
                    counts_next[i*CNTW +: CNTW] = counts_q[i*CNTW +: CNTW] + CNTW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pulse_prev <= '0;
            target_q   <= '0;
            total_q    <= '0;
            counts_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            pulse_prev <= bus.pulse;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        target_q <= bus.target;
                        total_q  <= '0;
                        counts_q <= '0;
                        ovf_q    <= 1'b0;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    total_q  <= total_next;
                    counts_q <= counts_next;
                    if (sum_ovf || cnt_ovf) begin
                        ovf_q <= 1'b1;
                    end
                    // A zero target completes on the first ACCUM edge.
                    if (total_next >= target_q) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // ack has priority; start is simply not looked at here.
                    if (bus.ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out    = (state == ST_DONE);
    assign bus.busy   = (state == ST_ACCUM);
    assign bus.counts = counts_q;
    assign bus.total  = total_q;
    assign bus.ovf    = ovf_q;
    // DONE is only reached with total >= target, so this never goes negative.
    assign bus.change = (state == ST_DONE) ? (total_q - target_q) : '0;

endmodule

// File: tb/tb_money_accumulator.sv
// ----------------------------------------------------------------------------
// tb_money_accumulator
// Purpose : directed stimulus for money_accumulator with a transaction-level
//           reference model, a per-cycle compare process and literal checks.
// ----------------------------------------------------------------------------
module tb_money_accumulator;

    localparam int NCH  = 3;
    localparam int VALW = 19;
    localparam int CNTW = 9;
    localparam int MAXV = 524287;
    localparam int MAXC = 511;
    localparam int DEN [3] = '{1000, 2000, 5000};

    logic clk;
    logic rst;

    money_accumulator_if #(.NCH(NCH), .VALW(VALW), .CNTW(CNTW)) bus ();

    money_accumulator #(.NCH(NCH), .VALW(VALW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit         m_active;
    bit         m_done;
    bit         m_ovf;
    int         m_total;
    int         m_target;
    int         m_cnt [3];
    logic [2:0] m_prev;
    int         gained;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_total  = 0;
            m_target = 0;
            m_cnt    = '{0, 0, 0};
            m_prev   = '0;
        end else begin
            if (m_active) begin
                gained = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (bus.pulse[i] && !m_prev[i]) begin
                        gained += DEN[i];
                        if (m_cnt[i] == MAXC) m_ovf = 1'b1;
                        else m_cnt[i]++;
                    end
                end
                if (m_total + gained > MAXV) begin
                    m_total = MAXV;
                    m_ovf   = 1'b1;
                end else begin
                    m_total += gained;
                end
                if (m_total >= m_target) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (m_done) begin
                if (bus.ack) m_done = 1'b0;
            end else if (bus.start) begin
                m_target = int'(bus.target);
                m_total  = 0;
                m_cnt    = '{0, 0, 0};
                m_ovf    = 1'b0;
                m_active = 1'b1;
            end
            m_prev = bus.pulse;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out",    bus.out,    m_done);
            check("busy",   bus.busy,   m_active);
            check("total",  bus.total,  m_total);
            check("change", bus.change, m_done ? m_total - m_target : 0);
            check("ovf",    bus.ovf,    m_ovf);
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("count%0d", i), bus.counts[i*CNTW +: CNTW], m_cnt[i]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input int tgt);
        bus.target = VALW'(tgt);
        bus.start  = 1'b1;
        tick(1);
        bus.start  = 1'b0;
    endtask

    task automatic pulse_edge(input logic [2:0] mask);
        bus.pulse = mask;
        tick(1);
        bus.pulse = '0;
        tick(1);
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.ack    = 1'b0;
        bus.pulse  = '0;
        bus.target = '0;
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("rst_out",   bus.out,   0);
        check("rst_busy",  bus.busy,  0);
        check("rst_total", bus.total, 0);
        check("rst_ovf",   bus.ovf,   0);

        // Target 28000, edges 5000/2000/1000 in turn; stops at 29000.
        start_txn(28000);
        check("a_busy", bus.busy, 1);
        k = 0;
        while (!bus.out && k < 15) begin
            pulse_edge(3'b100 >> (k % 3));
            k++;
        end
        check("a_out",    bus.out,    1);
        check("a_total",  bus.total,  29000);
        check("a_change", bus.change, 1000);
        check("a_cnt2",   bus.counts[2*CNTW +: CNTW], 4);
        check("a_cnt1",   bus.counts[1*CNTW +: CNTW], 3);
        check("a_cnt0",   bus.counts[0*CNTW +: CNTW], 3);
        pulse_edge(3'b001);
        start_txn(1000);
        check("a_done_hold", bus.total, 29000);
        do_ack();
        check("a_idle_out",    bus.out,    0);
        check("a_idle_total",  bus.total,  29000);
        check("a_idle_change", bus.change, 0);

        // Held level across entry, long hold in ACCUM, simultaneous edges.
        bus.pulse = 3'b100;
        start_txn(328000);
        tick(10);
        check("b_entry_total", bus.total, 0);
        bus.pulse = '0;
        tick(1);
        bus.pulse = 3'b100;
        tick(10);
        bus.pulse = '0;
        tick(1);
        check("b_hold_total", bus.total, 5000);
        check("b_hold_cnt2",  bus.counts[2*CNTW +: CNTW], 1);
        pulse_edge(3'b111);
        check("b_sim_total", bus.total, 13000);
        check("b_sim_cnt0",  bus.counts[0*CNTW +: CNTW], 1);
        check("b_sim_busy",  bus.busy, 1);
        do_ack();
        check("b_ack_ignored", bus.busy, 1);
        rst = 1'b1; bus.start = 1'b1; bus.pulse = 3'b010;
        tick(1);
        check("b_rst_total", bus.total, 0);
        check("b_rst_busy",  bus.busy,  0);
        rst = 1'b0; bus.start = 1'b0;
        tick(2);
        bus.pulse = '0;
        pulse_edge(3'b001);
        check("b_idle_total", bus.total, 0);

        // Reset mid-ACCUM at 7000.
        start_txn(100000);
        pulse_edge(3'b100);
        pulse_edge(3'b010);
        check("c_total", bus.total, 7000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("c_rst_total", bus.total, 0);
        check("c_rst_busy",  bus.busy,  0);
        check("c_rst_cnt2",  bus.counts[2*CNTW +: CNTW], 0);
        pulse_edge(3'b100);
        check("c_ignored", bus.total, 0);

        // Zero target completes on the second edge; start+ack -> ack wins.
        start_txn(0);
        check("d_edge1_out",  bus.out,  0);
        check("d_edge1_busy", bus.busy, 1);
        tick(1);
        check("d_out",    bus.out,    1);
        check("d_total",  bus.total,  0);
        check("d_change", bus.change, 0);
        bus.start = 1'b1; bus.ack = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.ack = 1'b0;
        check("d_ack_out",  bus.out,  0);
        check("d_ack_busy", bus.busy, 0);

        // Total saturation with target = all-ones.
        start_txn(MAXV);
        k = 0;
        while (!bus.out && k < 200) begin
            pulse_edge(3'b100);
            k++;
        end
        check("e_out",    bus.out,    1);
        check("e_total",  bus.total,  MAXV);
        check("e_ovf",    bus.ovf,    1);
        check("e_change", bus.change, 0);
        check("e_cnt2",   bus.counts[2*CNTW +: CNTW], 105);
        do_ack();

        // Count saturation on channel 0 before the total saturates.
        start_txn(MAXV);
        repeat (511) pulse_edge(3'b001);
        check("f_pre_ovf", bus.ovf, 0);
        pulse_edge(3'b001);
        check("f_cnt0",  bus.counts[0*CNTW +: CNTW], MAXC);
        check("f_ovf",   bus.ovf,   1);
        check("f_total", bus.total, 512000);
        check("f_busy",  bus.busy,  1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
